// File: rtl/redmule_pkg.sv
// Shared constants and types for the RedMulE TCDM responder model.
// LFSR constants are only consumed when REDMULE_TCDM_STALL_EN is defined.
package redmule_pkg;

  localparam logic [31:0] TCDM_ERR_DATA  = 32'hDEAD_BEEF;
  localparam logic [15:0] TCDM_LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR land on state bits 0,2,3,5.
  localparam logic [15:0] TCDM_LFSR_TAPS = 16'h002D;

  typedef enum logic [1:0] {
    RSP_READ   = 2'd0,
    RSP_WRITE  = 2'd1,
    RSP_ERR_RD = 2'd2,
    RSP_ERR_WR = 2'd3
  } tcdm_rsp_e;

  function automatic logic [15:0] tcdm_lfsr_next(input logic [15:0] s);
    return {^(s & TCDM_LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/redmule_tcdm_bank_arb.sv
// Round-robin arbiter for one TCDM bank; the priority pointer only moves
// when the bank is actually contended.
module redmule_tcdm_bank_arb #(
  parameter int unsigned MP = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [MP-1:0] req_i,
  output logic [MP-1:0] gnt_o
);

  localparam int unsigned PTR_W = (MP > 1) ? $clog2(MP) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d, winner, pi;
  logic             found;
  int unsigned      idx;

  always_comb begin
    gnt_o  = '0;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    pi     = '0;
    for (int unsigned i = 0; i < MP; i++) begin
      idx = (32'(ptr_q) + i) % MP;
      pi  = PTR_W'(idx);
      if (!found && req_i[pi]) begin
        found     = 1'b1;
        winner    = pi;
        gnt_o[pi] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if ($countones(req_i) > 1) begin
      ptr_d = (winner == PTR_W'(MP - 1)) ? '0 : winner + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/redmule_tcdm_responder.sv
// Multi-port word-interleaved TCDM responder with per-bank round-robin arbitration.
// Optional grant stalling via per-port LFSRs when REDMULE_TCDM_STALL_EN is defined.
module redmule_tcdm_responder
  import redmule_pkg::*;
#(
  parameter int unsigned MP         = 4,
  parameter int unsigned NB_BANKS   = 8,
  parameter int unsigned BANK_WORDS = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [MP-1:0]        tcdm_req_i,
  output logic [MP-1:0]        tcdm_gnt_o,
  input  logic [MP-1:0][31:0]  tcdm_add_i,
  input  logic [MP-1:0]        tcdm_wen_i,
  input  logic [MP-1:0][3:0]   tcdm_be_i,
  input  logic [MP-1:0][31:0]  tcdm_data_i,
  output logic [MP-1:0][31:0]  tcdm_r_data_o,
  output logic [MP-1:0]        tcdm_r_valid_o,
  output logic                 tcdm_r_opc_o,
  output logic                 tcdm_r_user_o
);

  localparam int unsigned N_WORDS   = NB_BANKS * BANK_WORDS;
  localparam int unsigned MEM_AW    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int unsigned BANK_W    = (NB_BANKS > 1) ? $clog2(NB_BANKS) : 1;
  localparam logic [31:0] N_WORDS_W = 32'(N_WORDS);

  logic [29:0]                  word;
  logic [MP-1:0]                err;
  logic [MP-1:0][BANK_W-1:0]    bank;
  logic [MP-1:0][MEM_AW-1:0]    waddr;
  tcdm_rsp_e                    kind [MP];
  logic [MP-1:0]                req_eff, mem_gnt, gnt;
  logic [NB_BANKS-1:0][MP-1:0]  bank_req, bank_gnt;

  logic [31:0]                  mem_q [N_WORDS];
  logic [MP-1:0]                r_valid_q;
  logic [MP-1:0][31:0]          r_data_q;
  logic                         r_opc_q;

  // Address decode: addresses below BASE_ADDR wrap to huge word indices and fail the range check too.
  always_comb begin
    word  = '0;
    err   = '0;
    bank  = '0;
    waddr = '0;
    for (int unsigned p = 0; p < MP; p++) begin
      word     = 30'((tcdm_add_i[p] - BASE_ADDR) >> 2);
      err[p]   = (tcdm_add_i[p] < BASE_ADDR) || ({2'b00, word} >= N_WORDS_W);
      bank[p]  = (NB_BANKS > 1) ? word[BANK_W-1:0] : '0;
      waddr[p] = word[MEM_AW-1:0];
      if (err[p]) begin
        kind[p] = tcdm_wen_i[p] ? RSP_ERR_RD : RSP_ERR_WR;
      end else begin
        kind[p] = tcdm_wen_i[p] ? RSP_READ : RSP_WRITE;
      end
    end
  end

`ifdef REDMULE_TCDM_STALL_EN
  logic [MP-1:0][15:0] lfsr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned p = 0; p < MP; p++) begin
        lfsr_q[p] <= TCDM_LFSR_SEED ^ 16'(p);
      end
    end else begin
      for (int unsigned p = 0; p < MP; p++) begin
        lfsr_q[p] <= tcdm_lfsr_next(lfsr_q[p]);
      end
    end
  end

  // A stalled port is withdrawn before arbitration so it cannot block others.
  always_comb begin
    for (int unsigned p = 0; p < MP; p++) begin
      req_eff[p] = tcdm_req_i[p] & lfsr_q[p][0];
    end
  end
`else
  assign req_eff = tcdm_req_i;
`endif

  // Out-of-range requests touch no bank, so they never compete for one.
  always_comb begin
    bank_req = '0;
    for (int unsigned p = 0; p < MP; p++) begin
      if (req_eff[p] && !err[p]) begin
        bank_req[bank[p]][p] = 1'b1;
      end
    end
  end

  for (genvar b = 0; b < NB_BANKS; b++) begin : gen_bank
    redmule_tcdm_bank_arb #(
      .MP (MP)
    ) i_bank_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req_i  (bank_req[b]),
      .gnt_o  (bank_gnt[b])
    );
  end

  always_comb begin
    mem_gnt = '0;
    gnt     = '0;
    for (int unsigned p = 0; p < MP; p++) begin
      mem_gnt[p] = bank_gnt[bank[p]][p];
      gnt[p]     = rst_ni & req_eff[p] & (err[p] | mem_gnt[p]);
    end
  end

  assign tcdm_gnt_o = gnt;

  // Memory array is intentionally not reset; one writer per bank per cycle by construction.
  always_ff @(posedge clk_i) begin
    for (int unsigned p = 0; p < MP; p++) begin
      if (gnt[p] && kind[p] == RSP_WRITE) begin
        for (int unsigned l = 0; l < 4; l++) begin
          if (tcdm_be_i[p][l]) begin
            mem_q[waddr[p]][8*l +: 8] <= tcdm_data_i[p][8*l +: 8];
          end
        end
      end
    end
  end

  // Response stage: reads sample the array before this edge's writes land.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_q <= '0;
      r_data_q  <= '0;
      r_opc_q   <= 1'b0;
    end else begin
      r_valid_q <= gnt;
      r_opc_q   <= |(gnt & err);
      for (int unsigned p = 0; p < MP; p++) begin
        if (gnt[p]) begin
          case (kind[p])
            RSP_READ:   r_data_q[p] <= mem_q[waddr[p]];
            RSP_ERR_RD: r_data_q[p] <= TCDM_ERR_DATA;
            default:    r_data_q[p] <= '0;
          endcase
        end
      end
    end
  end

  assign tcdm_r_valid_o = r_valid_q;
  assign tcdm_r_data_o  = r_data_q;
  assign tcdm_r_opc_o   = r_opc_q;
  assign tcdm_r_user_o  = 1'b0;

endmodule

// File: tb/tb_redmule_tcdm_responder.sv
// Directed bench for redmule_tcdm_responder (MP=4, 8 banks, 256 words/bank, stall off)
// with a cycle-level reference model checked every cycle plus literal spot checks.
module tb_redmule_tcdm_responder;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        req, wen, gnt, r_valid;
  logic [3:0][31:0]  add, wdata, r_data;
  logic [3:0][3:0]   be;
  logic              r_opc, r_user;

  int vectors = 0;
  int miss    = 0;

  always #5 clk = ~clk;

  redmule_tcdm_responder #(
    .MP         (4),
    .NB_BANKS   (8),
    .BANK_WORDS (256),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .tcdm_req_i     (req),
    .tcdm_gnt_o     (gnt),
    .tcdm_add_i     (add),
    .tcdm_wen_i     (wen),
    .tcdm_be_i      (be),
    .tcdm_data_i    (wdata),
    .tcdm_r_data_o  (r_data),
    .tcdm_r_valid_o (r_valid),
    .tcdm_r_opc_o   (r_opc),
    .tcdm_r_user_o  (r_user)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mm [int unsigned];
  int          ptr [8];
  logic [3:0]  pend_v, pend_k;
  logic [31:0] pend_d [4];
  logic        pend_opc;

  function automatic bit m_err(input logic [31:0] a);
    longint unsigned w;
    if (a < BASE) return 1'b1;
    w = longint'(a - BASE) / 4;
    return w >= 2048;
  endfunction

  function automatic int unsigned m_word(input logic [31:0] a);
    return (a - BASE) / 4;
  endfunction

  initial begin : compare
    logic [3:0] eg;
    int         n, w;
    logic [31:0] v;
    pend_v = '0; pend_k = '0; pend_opc = 1'b0;
    for (int b = 0; b < 8; b++) ptr[b] = 0;
    for (int p = 0; p < 4; p++) pend_d[p] = '0;
    forever begin
      @(negedge clk);
      chk("r_user", {31'd0, r_user}, 32'd0);
      if (!rst_n) begin
        chk("gnt_in_reset", {28'd0, gnt}, 32'd0);
        chk("r_valid_in_reset", {28'd0, r_valid}, 32'd0);
        chk("r_opc_in_reset", {31'd0, r_opc}, 32'd0);
        pend_v = '0; pend_opc = 1'b0;
        for (int b = 0; b < 8; b++) ptr[b] = 0;
      end else begin
        eg = '0;
        for (int b = 0; b < 8; b++) begin
          n = 0; w = -1;
          for (int p = 0; p < 4; p++)
            if (req[p] && !m_err(add[p]) && (m_word(add[p]) % 8) == b) n++;
          for (int i = 0; i < 4; i++) begin
            int q;
            q = (ptr[b] + i) % 4;
            if (w < 0 && req[q] && !m_err(add[q]) && (m_word(add[q]) % 8) == b) w = q;
          end
          if (w >= 0) eg[w] = 1'b1;
          if (n > 1) ptr[b] = (w + 1) % 4;
        end
        for (int p = 0; p < 4; p++) if (req[p] && m_err(add[p])) eg[p] = 1'b1;

        chk("gnt", {28'd0, gnt}, {28'd0, eg});
        chk("r_valid", {28'd0, r_valid}, {28'd0, pend_v});
        chk("r_opc", {31'd0, r_opc}, {31'd0, pend_opc});
        for (int p = 0; p < 4; p++)
          if (pend_v[p] && pend_k[p]) chk($sformatf("r_data[%0d]", p), r_data[p], pend_d[p]);

        pend_v = eg; pend_k = '0; pend_opc = 1'b0;
        for (int p = 0; p < 4; p++) begin
          if (!eg[p]) continue;
          if (m_err(add[p])) begin
            pend_opc = 1'b1;
            if (wen[p]) begin pend_d[p] = 32'hDEAD_BEEF; pend_k[p] = 1'b1; end
          end else if (wen[p]) begin
            pend_k[p] = mm.exists(m_word(add[p]));
            if (pend_k[p]) pend_d[p] = mm[m_word(add[p])];
          end else begin
            pend_d[p] = 32'd0; pend_k[p] = 1'b1;
          end
        end
        for (int p = 0; p < 4; p++) begin
          if (eg[p] && !wen[p] && !m_err(add[p])) begin
            if (be[p] == 4'hF) mm[m_word(add[p])] = wdata[p];
            else if (mm.exists(m_word(add[p]))) begin
              v = mm[m_word(add[p])];
              for (int l = 0; l < 4; l++) if (be[p][l]) v[8*l +: 8] = wdata[p][8*l +: 8];
              mm[m_word(add[p])] = v;
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    req = '0; wen = '1; add = '0; be = '0; wdata = '0;
  endtask

  task automatic setp(input int p, input logic rd, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] d);
    req[p] = 1'b1; wen[p] = rd; add[p] = a; be[p] = b; wdata[p] = d;
  endtask

  initial begin : stim
    rst_n = 1'b0;
    clear_all();
    tick();
    req = 4'hF; add = {4{BASE}};
    #1;
    chk("lit_gnt_held_in_reset", {28'd0, gnt}, 32'd0);
    tick();
    for (int p = 0; p < 4; p++) chk("lit_rdata_reset", r_data[p], 32'd0);
    chk("lit_rvalid_reset", {28'd0, r_valid}, 32'd0);
    clear_all();
    rst_n = 1'b1;
    tick();

    // single write then read-back on port 0
    setp(0, 1'b0, BASE, 4'hF, 32'hCAFE_F00D);
    #1 chk("lit_wr_gnt", {28'd0, gnt}, 32'h1);
    tick();
    chk("lit_wr_rvalid", {28'd0, r_valid}, 32'h1);
    chk("lit_wr_rdata", r_data[0], 32'd0);
    clear_all();
    setp(0, 1'b1, BASE, 4'h0, 32'd0);
    tick();
    chk("lit_rd_rdata", r_data[0], 32'hCAFE_F00D);
    chk("lit_rd_opc", {31'd0, r_opc}, 32'd0);
    clear_all();

    // four writes to four different banks in one cycle
    setp(0, 1'b0, BASE + 32'h20, 4'hF, 32'hAAAA_0020);
    setp(1, 1'b0, BASE + 32'h04, 4'hF, 32'h1111_0004);
    setp(2, 1'b0, BASE + 32'h08, 4'hF, 32'h2222_0008);
    setp(3, 1'b0, BASE + 32'h0C, 4'hF, 32'h3333_000C);
    #1 chk("lit_par_wr_gnt", {28'd0, gnt}, 32'hF);
    tick();
    clear_all();

    // conflict-free parallel reads
    for (int p = 0; p < 4; p++) setp(p, 1'b1, BASE + 32'(4 * p), 4'h0, 32'd0);
    #1 chk("lit_par_rd_gnt", {28'd0, gnt}, 32'hF);
    tick();
    chk("lit_par_rd_rvalid", {28'd0, r_valid}, 32'hF);
    chk("lit_par_rd_d1", r_data[1], 32'h1111_0004);
    chk("lit_par_rd_d3", r_data[3], 32'h3333_000C);
    clear_all();

    // all ports on bank 0, held for four cycles: round-robin 0,1,2,3
    for (int p = 0; p < 4; p++) setp(p, 1'b1, BASE + 32'h20, 4'h0, 32'd0);
    for (int k = 0; k < 4; k++) begin
      #1 chk("lit_rr_gnt", {28'd0, gnt}, 32'(1 << k));
      tick();
      chk("lit_rr_rvalid", {28'd0, r_valid}, 32'(1 << k));
      chk("lit_rr_rdata", r_data[k], 32'hAAAA_0020);
    end
    clear_all();
    tick();

    // byte-masked write
    setp(2, 1'b0, BASE + 32'h10, 4'hF, 32'hFFFF_FFFF);
    tick();
    setp(2, 1'b0, BASE + 32'h10, 4'b0101, 32'h0000_0000);
    tick();
    setp(2, 1'b1, BASE + 32'h10, 4'h0, 32'd0);
    tick();
    chk("lit_be_rdata", r_data[2], 32'hFF00_FF00);
    clear_all();

    // partial contention: ports 0,2 on bank 3, port 1 on bank 5
    setp(0, 1'b1, BASE + 32'h0C, 4'h0, 32'd0);
    setp(1, 1'b1, BASE + 32'h14, 4'h0, 32'd0);
    setp(2, 1'b1, BASE + 32'h2C, 4'h0, 32'd0);
    #1 chk("lit_part_gnt0", {28'd0, gnt}, 32'b0011);
    tick();
    #1 chk("lit_part_gnt1", {28'd0, gnt}, 32'b0110);
    tick();
    clear_all();

    // out-of-range accesses
    setp(1, 1'b1, BASE + 32'h2000, 4'h0, 32'd0);
    #1 chk("lit_err_gnt", {28'd0, gnt}, 32'b0010);
    tick();
    chk("lit_err_rdata", r_data[1], 32'hDEAD_BEEF);
    chk("lit_err_opc", {31'd0, r_opc}, 32'd1);
    clear_all();
    setp(0, 1'b1, BASE - 32'd4, 4'h0, 32'd0);
    setp(1, 1'b1, BASE, 4'h0, 32'd0);
    setp(3, 1'b0, BASE + 32'h2004, 4'hF, 32'h1234_5678);
    #1 chk("lit_err_mix_gnt", {28'd0, gnt}, 32'b1011);
    tick();
    chk("lit_err_low_rdata", r_data[0], 32'hDEAD_BEEF);
    chk("lit_err_mix_rdata1", r_data[1], 32'hCAFE_F00D);
    clear_all();
    tick();
    chk("lit_opc_idle", {31'd0, r_opc}, 32'd0);

    // reset right after a grant drops the pending response, keeps memory
    setp(0, 1'b1, BASE, 4'h0, 32'd0);
    tick();
    rst_n = 1'b0;
    #1 chk("lit_rst_rvalid", {28'd0, r_valid}, 32'd0);
    tick();
    chk("lit_rst_gnt", {28'd0, gnt}, 32'd0);
    clear_all();
    rst_n = 1'b1;
    tick();
    chk("lit_post_rst_rvalid", {28'd0, r_valid}, 32'd0);
    setp(0, 1'b1, BASE, 4'h0, 32'd0);
    setp(1, 1'b1, BASE + 32'h04, 4'h0, 32'd0);
    tick();
    chk("lit_post_rst_d0", r_data[0], 32'hCAFE_F00D);
    chk("lit_post_rst_d1", r_data[1], 32'h1111_0004);
    clear_all();
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule

// File: doc/redmule_tcdm_responder.md
REDMULE_TCDM_RESPONDER -- requirements
Module: redmule_tcdm_responder

Interface
REQ-001 SHALL have parameter MP, default 4, number of 32-bit TCDM slave ports.
REQ-002 SHALL have parameter NB_BANKS, default 8, number of word-interleaved banks (power of 2, >= MP).
REQ-003 SHALL have parameter BANK_WORDS, default 256, 32-bit words per bank (power of 2).
REQ-004 SHALL have parameter BASE_ADDR, default 32'h1000_0000, byte address of word 0.
REQ-005 SHALL have clk_i  input  1  the single clock of the block.
REQ-006 SHALL have rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have tcdm_req_i  input  [MP-1:0]  per-port request.
REQ-008 SHALL have tcdm_gnt_o  output  [MP-1:0]  per-port grant.
REQ-009 SHALL have tcdm_add_i  input  [MP-1:0][31:0]  byte address.
REQ-010 SHALL have tcdm_wen_i  input  [MP-1:0]  1 = read, 0 = write.
REQ-011 SHALL have tcdm_be_i  input  [MP-1:0][3:0]  byte enables.
REQ-012 SHALL have tcdm_data_i  input  [MP-1:0][31:0]  write data.
REQ-013 SHALL have tcdm_r_data_o  output  [MP-1:0][31:0]  read data.
REQ-014 SHALL have tcdm_r_valid_o  output  [MP-1:0]  response valid.
REQ-015 SHALL have tcdm_r_opc_o  output  1  error flag; tcdm_r_user_o  output  1  tied 0.

Function
REQ-016 SHALL decode word = (add - BASE_ADDR) >> 2; bank = word mod NB_BANKS; row = word / NB_BANKS; add[1:0] ignored.
REQ-017 SHALL grant at most one port per bank per cycle; gnt combinational from req in the same cycle.
REQ-018 SHALL arbitrate each bank round-robin: per-bank pointer moves to (winner+1) mod MP only when that bank sees >1 requester.
REQ-019 SHALL grant a port not conflicting with any other port in the same cycle it requests.
REQ-020 SHALL perform a granted write as a byte-masked update: only lanes with be=1 change.
REQ-021 SHALL assert tcdm_r_valid_o[p] exactly one cycle after each grant on port p, for reads and writes.
REQ-022 SHALL drive r_data with the row content before any same-cycle write for reads, and 32'h0 for write responses.
REQ-023 SHALL treat word >= NB_BANKS*BANK_WORDS (including add < BASE_ADDR) as error: granted, write dropped, read data 32'hDEAD_BEEF, r_opc=1 in the response cycle.
REQ-024 SHALL drive r_opc=0 in every cycle with no error response; r_opc is the OR over ports.
REQ-025 SHALL make a write granted in cycle N visible to any read granted in cycle N+1 or later.
REQ-026 SHALL tolerate req dropping without gnt; no state is kept for ungranted requests.

Reset
REQ-027 SHALL clear r_valid, r_data, r_opc, round-robin pointers and stall LFSR state asynchronously on rst_ni low.
REQ-028 SHALL not reset memory contents; a response pending at reset assertion SHALL be discarded.
REQ-029 SHALL hold gnt_o at 0 while rst_ni is low.

Configuration
REQ-030 SHALL, with REDMULE_TCDM_STALL_EN defined, mask each gnt[p] with bit 0 of a per-port 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 xor p), advanced every cycle; a masked port loses arbitration.
REQ-031 SHALL, without REDMULE_TCDM_STALL_EN, grant purely by REQ-017..019 and contain no LFSR logic.

Structure
REQ-032 SHALL place TCDM_ERR_DATA (32'hDEAD_BEEF) and LFSR seed/taps constants in redmule_pkg.
REQ-033 SHALL instantiate NB_BANKS instances of sub-module redmule_tcdm_bank_arb (round-robin arbiter + pointer register).

Verification (MP=4, NB_BANKS=8, BANK_WORDS=256, stall off)
REQ-034 SHALL cover: port0 write 0x1000_0000 data 0xCAFE_F00D be=4'hF, then read -> r_valid cycle+1, r_data 0xCAFE_F00D, r_opc 0.
REQ-035 SHALL cover: ports 0..3 read 0x1000_0000/04/08/0C same cycle -> all gnt=1, all r_valid next cycle.
REQ-036 SHALL cover: ports 0..3 all read 0x1000_0020 (bank 0) held 4 cycles -> one gnt per cycle, order 0,1,2,3, each r_valid one cycle after its gnt.
REQ-037 SHALL cover: word 0xFFFF_FFFF at 0x1000_0010, then write be=4'b0101 data 0 -> read returns 0xFF00_FF00.
REQ-038 SHALL cover: read 0x1000_2000 (out of range) -> gnt, r_data 0xDEAD_BEEF, r_opc=1 one cycle later.
REQ-039 SHALL cover: rst_ni low in the cycle after a grant -> r_valid 0, no response after release, prior memory data still readable.
